// File: rtl/branch_resolve_unit.sv
// Branch resolution and next-PC stage: evaluates condition codes on forwarded or
// stored ALU flags, owns the fetch PC, squashes wrong-path slots and counts taken branches.
module branch_resolve_unit #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flag_we,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             flag_c,
  input  logic             flag_v,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  pc,
  output logic             taken,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int unsigned FC_W     = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;
  localparam bit          FLUSH_EN = (FLUSH_DEPTH > 0);

  localparam logic [2:0] CC_EQ  = 3'b000;
  localparam logic [2:0] CC_NE  = 3'b001;
  localparam logic [2:0] CC_LT  = 3'b010;
  localparam logic [2:0] CC_GE  = 3'b011;
  localparam logic [2:0] CC_LTU = 3'b100;
  localparam logic [2:0] CC_GEU = 3'b101;
  localparam logic [2:0] CC_AL  = 3'b110;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t            state, state_next;
  logic [FC_W-1:0]   fcnt, fcnt_next;
  logic [3:0]        flags_q;
  logic              eff_z, eff_n, eff_c, eff_v;
  logic              cond_true;
  logic              resolve;
  logic              take;
  logic [PC_W-1:0]   pc_next;
  logic [CNT_W-1:0]  cnt_next;

  // Same-cycle forwarding of the flags being written.
  always_comb begin
    if (flag_we) begin
      {eff_z, eff_n, eff_c, eff_v} = {flag_z, flag_n, flag_c, flag_v};
    end else begin
      {eff_z, eff_n, eff_c, eff_v} = flags_q;
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      CC_EQ:   cond_true = eff_z;
      CC_NE:   cond_true = ~eff_z;
      CC_LT:   cond_true = eff_n ^ eff_v;
      CC_GE:   cond_true = ~(eff_n ^ eff_v);
      CC_LTU:  cond_true = ~eff_c;
      CC_GEU:  cond_true = eff_c;
      CC_AL:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Branches arriving while squashing are wrong-path and never resolve.
  assign resolve = br_valid & ~stall & (state != S_FLUSH);
  assign take    = resolve & cond_true;

  // Flush FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      fcnt  <= '0;
      flush <= 1'b0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
      flush <= (state_next == S_FLUSH);
    end
  end

  // Flush FSM next state; the window only advances on non-stalled edges.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    case (state)
      S_IDLE: begin
        if (take && FLUSH_EN) begin
          state_next = S_FLUSH;
          fcnt_next  = FC_W'(FLUSH_DEPTH);
        end
      end
      S_FLUSH: begin
        if (!stall) begin
          if (fcnt == FC_W'(1)) begin
            state_next = S_IDLE;
            fcnt_next  = '0;
          end else begin
            fcnt_next = fcnt - FC_W'(1);
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        fcnt_next  = '0;
      end
    endcase
  end

  // Next PC and saturating taken counter.
  always_comb begin
    pc_next  = pc;
    cnt_next = taken_cnt;
    if (!stall) begin
      pc_next = take ? br_target : pc + PC_W'(4);
    end
    if (take && (taken_cnt != {CNT_W{1'b1}})) begin
      cnt_next = taken_cnt + CNT_W'(1);
    end
  end

  // Datapath registers; flag capture ignores stall and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      taken     <= 1'b0;
      taken_cnt <= '0;
      flags_q   <= 4'b0000;
    end else begin
      pc        <= pc_next;
      taken     <= take;
      taken_cnt <= cnt_next;
      if (flag_we) begin
        flags_q <= {flag_z, flag_n, flag_c, flag_v};
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a default instance (FLUSH_DEPTH=2) and a
// FLUSH_DEPTH=0 / CNT_W=2 instance share stimulus; each cycle's expectation names its instance.
module tb_branch_resolve_unit;

  localparam logic [2:0] EQ = 3'b000, NE = 3'b001, LT = 3'b010, GE = 3'b011;
  localparam logic [2:0] LTU = 3'b100, GEU = 3'b101, AL = 3'b110, NV = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flag_we = 1'b0;
  logic        flag_z = 1'b0, flag_n = 1'b0, flag_c = 1'b0, flag_v = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_cond = 3'b000;
  logic [31:0] br_target = '0;

  logic [31:0] pc_a, pc_b;
  logic        taken_a, taken_b, flush_a, flush_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  typedef struct {
    int          step;
    logic        sel;
    logic [31:0] pc;
    logic        tk;
    logic        fl;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(32), .FLUSH_DEPTH(2), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
    .pc(pc_a), .taken(taken_a), .flush(flush_a), .taken_cnt(cnt_a)
  );

  branch_resolve_unit #(.PC_W(32), .FLUSH_DEPTH(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
    .pc(pc_b), .taken(taken_b), .flush(flush_b), .taken_cnt(cnt_b)
  );

  // Drive one cycle's inputs just after the edge and queue the outputs expected in that cycle.
  task automatic cyc(input logic r, input logic s, input logic we, input logic [3:0] f,
                     input logic bv, input logic [2:0] c, input logic [31:0] t,
                     input logic sel, input logic [31:0] epc, input logic etk,
                     input logic efl, input logic [7:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = s; flag_we = we;
    {flag_z, flag_n, flag_c, flag_v} = f;
    br_valid = bv; br_cond = c; br_target = t;
    step++;
    e.step = step; e.sel = sel; e.pc = epc; e.tk = etk; e.fl = efl; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the selected instance against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] apc;
      logic        atk, afl;
      logic [7:0]  acnt;
      e = exp_q.pop_front();
      if (e.sel) begin
        apc = pc_b; atk = taken_b; afl = flush_b; acnt = {6'd0, cnt_b};
      end else begin
        apc = pc_a; atk = taken_a; afl = flush_a; acnt = cnt_a;
      end
      checks++;
      if (apc !== e.pc || atk !== e.tk || afl !== e.fl || acnt !== e.cnt) begin
        errors++;
        $display("FAIL step%0d dut%0d: got pc=%h taken=%b flush=%b cnt=%0d, want pc=%h taken=%b flush=%b cnt=%0d",
                 e.step, e.sel, apc, atk, afl, acnt, e.pc, e.tk, e.fl, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   rst stall we  ZNCV    bv  cond tgt             sel pc            tk fl cnt
    cyc(1, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h0,        0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h0,        0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h4,        0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h8,        0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'hC,        0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h10,       0, 0, 0);
    // Store Z=1, then BEQ uses the registered flag.
    cyc(0, 0, 1, 4'b1000, 0, EQ,  32'h0,          0, 32'h14,       0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h18,       0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 1, EQ,  32'h100,        0, 32'h1C,       0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h100,      1, 1, 1);
    // Wrong-path branch inside the flush window is ignored.
    cyc(0, 0, 0, 4'b0000, 1, AL,  32'h200,        0, 32'h104,      0, 1, 1);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h108,      0, 0, 1);
    // Forwarding: register Z=0, BEQ with Z=1 written the same cycle is taken.
    cyc(0, 0, 1, 4'b0000, 0, EQ,  32'h0,          0, 32'h10C,      0, 0, 1);
    cyc(0, 0, 1, 4'b1000, 1, EQ,  32'h300,        0, 32'h110,      0, 0, 1);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h300,      1, 1, 2);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h304,      0, 1, 2);
    cyc(0, 0, 1, 4'b0000, 0, EQ,  32'h0,          0, 32'h308,      0, 0, 2);
    cyc(0, 0, 1, 4'b1000, 1, NE,  32'h400,        0, 32'h30C,      0, 0, 2);
    // Signed/unsigned codes: LT taken (N=1), GE not, LTU taken (C=0), GEU taken (C=1).
    cyc(0, 0, 1, 4'b0100, 1, LT,  32'h500,        0, 32'h310,      0, 0, 2);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h500,      1, 1, 3);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h504,      0, 1, 3);
    cyc(0, 0, 0, 4'b0000, 1, GE,  32'h600,        0, 32'h508,      0, 0, 3);
    cyc(0, 0, 0, 4'b0000, 1, LTU, 32'h700,        0, 32'h50C,      0, 0, 3);
    cyc(0, 0, 1, 4'b0010, 0, EQ,  32'h0,          0, 32'h700,      1, 1, 4);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h704,      0, 1, 4);
    cyc(0, 0, 0, 4'b0000, 1, GEU, 32'h800,        0, 32'h708,      0, 0, 4);
    // Two stalled cycles inside the window stretch flush to four cycles.
    cyc(0, 1, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h800,      1, 1, 5);
    cyc(0, 1, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h800,      0, 1, 5);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h800,      0, 1, 5);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h804,      0, 1, 5);
    cyc(0, 0, 0, 4'b0000, 1, NV,  32'h900,        0, 32'h808,      0, 0, 5);
    // A stalled ALWAYS branch does not resolve.
    cyc(0, 1, 0, 4'b0000, 1, AL,  32'h900,        0, 32'h80C,      0, 0, 5);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h80C,      0, 0, 5);
    // Reset asserted mid-flush clears outputs before any clock edge.
    cyc(0, 0, 0, 4'b0000, 1, AL,  32'hA00,        0, 32'h810,      0, 0, 5);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'hA00,      1, 1, 6);
    cyc(1, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h0,        0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h0,        0, 0, 0);
    // PC wraps from 0xFFFFFFFC to 0.
    cyc(0, 0, 0, 4'b0000, 1, AL,  32'hFFFF_FFFC,  0, 32'h4,        0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'hFFFF_FFFC,1, 1, 1);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'h0,        0, 1, 1);
    // First branch after flush drops resolves in that cycle.
    cyc(0, 0, 0, 4'b0000, 1, AL,  32'hB00,        0, 32'h4,        0, 0, 1);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'hB00,      1, 1, 2);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'hB04,      0, 1, 2);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          0, 32'hB08,      0, 0, 2);
    // FLUSH_DEPTH=0, CNT_W=2 instance: back-to-back taken branches, counter saturates at 3.
    cyc(1, 0, 0, 4'b0000, 0, EQ,  32'h0,          1, 32'h0,        0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 1, AL,  32'h40,         1, 32'h0,        0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 1, AL,  32'h80,         1, 32'h40,       1, 0, 1);
    cyc(0, 0, 0, 4'b0000, 1, AL,  32'hC0,         1, 32'h80,       1, 0, 2);
    cyc(0, 0, 0, 4'b0000, 1, AL,  32'h10,         1, 32'hC0,       1, 0, 3);
    cyc(0, 0, 0, 4'b0000, 1, AL,  32'h20,         1, 32'h10,       1, 0, 3);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          1, 32'h20,       1, 0, 3);
    cyc(0, 0, 0, 4'b0000, 0, EQ,  32'h0,          1, 32'h24,       0, 0, 3);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and next-PC stage for the RISC CPU. It replaces the combinational Branch/Branch_not/Zero_flag select (M7) with a registered unit that has the following behaviour:
- stores ALU flags and evaluates eight condition codes;
- forwards same-cycle flags;
- owns the program counter;
- squashes a configurable number of wrong-path slots after a taken branch;
- counts taken branches.

It sits between the ALU flag outputs and the instruction-fetch address.

## Interface
Parameters:
- PC_W, 32, program counter and target width
- FLUSH_DEPTH, 2, number of cycles flush is held after a taken branch (0 disables flush)
- CNT_W, 8, width of the saturating taken-branch counter

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  freezes pc, the flush counter and branch resolution
- flag_we  in  1  captures flag_z/n/c/v into the flag register
- flag_z, flag_n, flag_c, flag_v  in  1 each  ALU zero, negative, carry and overflow flags
- br_valid  in  1  a branch or jump is present this cycle
- br_cond  in  3  condition code (see Operation)
- br_target  in  PC_W  branch destination
- pc  out  PC_W  current fetch address
- taken  out  1  one-cycle pulse: the branch resolved last cycle was taken
- flush  out  1  squash the wrong-path instructions in the fetch and decode stages
- taken_cnt  out  CNT_W  saturating count of taken branches

## Operation
- Condition codes, with F the effective flags:
  - 000 EQ: Z
  - 001 NE: !Z
  - 010 LT: N^V
  - 011 GE: !(N^V)
  - 100 LTU: !C
  - 101 GEU: C
  - 110 ALWAYS: 1
  - 111 NEVER: 0
- Effective flags F:
  - when flag_we=1, F is the incoming flag_* values (same-cycle forwarding);
  - otherwise F is the flag register.
- Flag register capture:
  - captures on every edge where flag_we=1, regardless of stall or flush;
  - reset value is 0000.
- Resolve condition: br_valid & !stall & !flush. Decision d = cond(br_cond, F).
- Next PC on each edge:
  - if stall: pc holds;
  - else if resolve and d: pc <= br_target;
  - else: pc <= pc + 4, modulo 2^PC_W (wraps from all-ones-minus-3 to 0).
- Flush state: two states, IDLE and FLUSH, with a down-counter of ceil(log2(FLUSH_DEPTH+1)) bits.
  - IDLE -> FLUSH on resolve & d when FLUSH_DEPTH>0; the counter loads FLUSH_DEPTH.
  - In FLUSH, the counter decrements on each non-stalled edge.
  - FLUSH -> IDLE when the counter reaches 1 and decrements.
  - flush = (state==FLUSH).
- br_valid during flush is a wrong-path instruction: it is ignored, with no pc change, no taken and no count.
- taken is registered: it equals resolve & d from the previous edge. It is 0 when the previous edge was stalled.
- taken_cnt increments on each resolve & d and saturates at 2^CNT_W-1 (no wrap).
- FLUSH_DEPTH=0: the FSM stays in IDLE; flush is tied to 0.

## Timing
- Reset values: pc=0, taken=0, flush=0, taken_cnt=0, flag register=0, FSM=IDLE, flush counter=0.
- Reset is asynchronous: all outputs go to their reset values immediately on rst rising, including mid-flush or while stalled.
- Resolve latency: a branch at cycle t (edge t+1) gives:
  - pc=br_target visible in cycle t+1;
  - taken=1 in cycle t+1 only;
  - flush=1 in cycles t+1 .. t+FLUSH_DEPTH, extended by one cycle for each stalled cycle inside the window.
- Stall in cycle t holds pc, the FSM, the counter and taken_cnt, and forces taken=0 at t+1. Flag capture still occurs.
- Sequencing: the first branch accepted after flush deasserts is resolved normally in that same cycle.

## Test plan
- Reset, then 5 free-running cycles with br_valid=0 -> pc sequence 0,4,8,12,16,20. taken=0, flush=0.
- flag_we with Z=1 at cycle 2, then BEQ (000) with target 0x100 at cycle 4 -> pc=0x100 in cycle 5, taken pulse in cycle 5, flush high in cycles 5-6, taken_cnt=1.
- Same-cycle forwarding:
  - register Z=0; BEQ with flag_we=1, Z=1 in the same cycle -> taken.
  - repeat with BNE -> not taken, pc+4.
- Branch presented during flush (BEQ always-true, target 0x200, in cycle 6) -> ignored: pc increments and taken_cnt is unchanged.
- Stall:
  - stall=1 for 2 cycles inside the flush window -> pc frozen and flush extended to 4 cycles total.
  - rst pulsed mid-flush -> pc=0 and flush=0 immediately.
- CNT_W=2, 5 ALWAYS branches -> taken_cnt saturates at 3.
- pc=0xFFFFFFFC, no branch -> pc=0.
- FLUSH_DEPTH=0 -> flush is never asserted and back-to-back branches in consecutive cycles are both taken.
